// File: rtl/multi_channel_accumulator.sv
// multi_channel_accumulator
//
// Adds two operands, or accumulates an operand into one of CHANNELS
// per-channel running sums. Each request produces exactly one result, one
// cycle later, through a single-entry registered valid/ready output stage.
// Arithmetic can wrap or saturate, chosen per request. Each channel keeps a
// sticky overflow flag.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready = !out_valid || out_ready)
//   in_op               00 ADD, 01 ACC, 10 CLR, 11 READ
//   in_ch               target channel
//   in_a, in_b          operands (in_b is used by ADD only)
//   sat_en              1 = saturate on overflow, 0 = wrap
//   out_valid/out_ready result handshake
//   out_data, out_ch    result value and its channel
//   out_ovf             overflow occurred on this operation
//   out_err             in_ch was out of range; no state was changed
//   ovf_sticky          per-channel sticky overflow flags (set by ACC only)

module multi_channel_accumulator #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic                sat_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_ovf,
  output logic                out_err,
  output logic [CHANNELS-1:0] ovf_sticky
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ACC  = 2'b01,
    OP_CLR  = 2'b10,
    OP_READ = 2'b11
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] acc [CHANNELS];
  logic             accept;
  logic             ch_ok;
  logic [WIDTH-1:0] acc_sel;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] sum_res;
  logic [WIDTH-1:0] nxt_data;
  logic             nxt_ovf;

  assign op       = op_e'(in_op);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The compare is one bit wider than the index so CHANNELS == 2^CH_W fits.
  assign ch_ok = ({1'b0, in_ch} < (CH_W+1)'(CHANNELS));

  // Select the addressed accumulator. An out-of-range index reads as zero,
  // which keeps the mux free of any out-of-bounds array access.
  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ch == CH_W'(i)) begin
        acc_sel = acc[i];
      end
    end
  end

  // The sum is formed one bit wider so the carry out is the overflow flag.
  // The accumulator read comes straight from the registers, so back-to-back
  // ACC requests to one channel see each other's results with no bubble.
  always_comb begin
    if (op == OP_ADD) begin
      sum = {1'b0, in_a} + {1'b0, in_b};
    end else begin
      sum = {1'b0, acc_sel} + {1'b0, in_a};
    end
    sum_ovf = sum[WIDTH];
    sum_res = (sum_ovf && sat_en) ? '1 : sum[WIDTH-1:0];
  end

  // Result payload for the request currently on the input port.
  always_comb begin
    nxt_data = '0;
    nxt_ovf  = 1'b0;
    if (ch_ok) begin
      case (op)
        OP_ADD, OP_ACC: begin
          nxt_data = sum_res;
          nxt_ovf  = sum_ovf;
        end
        OP_READ: nxt_data = acc_sel;
        default: begin
          nxt_data = '0;
          nxt_ovf  = 1'b0;
        end
      endcase
    end
  end

  // Single-entry output register. A new request always overwrites the slot,
  // which is safe because acceptance implies the slot is empty or being read
  // at this same edge. Without a new request, a consumer accept empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= nxt_data;
      out_ch    <= in_ch;
      out_ovf   <= nxt_ovf;
      out_err   <= !ch_ok;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator and sticky state change only when a request is accepted for
  // an existing channel; a stalled block leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
      end
      ovf_sticky <= '0;
    end else if (accept && ch_ok) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_ch == CH_W'(i)) begin
          case (op)
            OP_ACC: begin
              acc[i] <= sum_res;
              if (sum_ovf) begin
                ovf_sticky[i] <= 1'b1;
              end
            end
            OP_CLR: begin
              acc[i]        <= '0;
              ovf_sticky[i] <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// tb_multi_channel_accumulator
//
// Directed bench for multi_channel_accumulator, built with CHANNELS = 3 so
// that channel index 3 exercises the out-of-range path. Expected results come
// from a small behavioural model, are queued when a request is driven and are
// popped when the result appears.

module tb_multi_channel_accumulator;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;
  localparam int CH_W     = 2;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ACC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_op;
  logic [CH_W-1:0]     in_ch;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic                sat_en;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_data;
  logic [CH_W-1:0]     out_ch;
  logic                out_ovf;
  logic                out_err;
  logic [CHANNELS-1:0] ovf_sticky;

  multi_channel_accumulator #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .CH_W    (CH_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_ch     (in_ch),
    .in_a      (in_a),
    .in_b      (in_b),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ovf   (out_ovf),
    .out_err   (out_err),
    .ovf_sticky(ovf_sticky)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CH_W-1:0]  ch;
    logic             ovf;
    logic             err;
  } exp_t;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb[$];

  logic [WIDTH-1:0]    model_acc [CHANNELS];
  logic [CHANNELS-1:0] model_sticky;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) model_acc[i] = '0;
    model_sticky = '0;
    sb.delete();
  endtask

  // Behavioural reference: predicts the result and updates the model state.
  task automatic model_step(input logic [1:0] op, input logic [CH_W-1:0] ch,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sat, output exp_t e);
    int full;
    int limit;
    limit  = (1 << WIDTH);
    e.ch   = ch;
    e.data = '0;
    e.ovf  = 1'b0;
    e.err  = 1'b0;
    if (int'(ch) >= CHANNELS) begin
      e.err = 1'b1;
    end else begin
      case (op)
        OP_ADD, OP_ACC: begin
          full = (op == OP_ADD) ? int'(a) + int'(b) : int'(model_acc[ch]) + int'(a);
          e.ovf = (full >= limit);
          if (e.ovf && sat) e.data = '1;
          else              e.data = WIDTH'(full % limit);
          if (op == OP_ACC) begin
            model_acc[ch] = e.data;
            if (e.ovf) model_sticky[ch] = 1'b1;
          end
        end
        OP_CLR: begin
          model_acc[ch]    = '0;
          model_sticky[ch] = 1'b0;
        end
        default: e.data = model_acc[ch];
      endcase
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [CH_W-1:0] ch,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic sat);
    in_op    = op;
    in_ch    = ch;
    in_a     = a;
    in_b     = b;
    sat_en   = sat;
    in_valid = 1'b1;
  endtask

  // Drives one request (assumed accepted at the next edge), queues its
  // expected result and returns 1 ns after that edge.
  task automatic apply_stimulus(input logic [1:0] op, input logic [CH_W-1:0] ch,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic sat);
    exp_t e;
    model_step(op, ch, a, b, sat, e);
    sb.push_back(e);
    drive(op, ch, a, b, sat);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s: observed result with empty scoreboard, expected a queued entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
      check({tag, "_data"},  32'(out_data),  32'(e.data));
      check({tag, "_ch"},    32'(out_ch),    32'(e.ch));
      check({tag, "_ovf"},   32'(out_ovf),   32'(e.ovf));
      check({tag, "_err"},   32'(out_err),   32'(e.err));
    end
  endtask

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish before 200 us");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_ch     = '0;
    in_a      = '0;
    in_b      = '0;
    sat_en    = 1'b0;
    out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_out_valid", 32'(out_valid),  32'(0));
    check("rst_in_ready",  32'(in_ready),   32'(1));
    check("rst_out_data",  32'(out_data),   32'(0));
    check("rst_out_ch",    32'(out_ch),     32'(0));
    check("rst_out_ovf",   32'(out_ovf),    32'(0));
    check("rst_out_err",   32'(out_err),    32'(0));
    check("rst_sticky",    32'(ovf_sticky), 32'(0));

    // Plain add
    apply_stimulus(OP_ADD, 2'd0, 8'h30, 8'h12, 1'b0);
    check_output("t1");
    check("t1_const", 32'(out_data), 32'h42);

    // Add overflow, wrap then saturate; sticky must not move
    apply_stimulus(OP_ADD, 2'd0, 8'hF0, 8'h20, 1'b0);
    check_output("t2_wrap");
    check("t2_wrap_const", 32'(out_data), 32'h10);
    apply_stimulus(OP_ADD, 2'd0, 8'hF0, 8'h20, 1'b1);
    check_output("t2_sat");
    check("t2_sat_const", 32'(out_data), 32'hFF);
    check("t2_sticky", 32'(ovf_sticky), 32'(0));

    // Channel 2 accumulate with saturation and sticky overflow
    apply_stimulus(OP_CLR, 2'd2, 8'h00, 8'h00, 1'b1);
    check_output("t3_clr");
    apply_stimulus(OP_ACC, 2'd2, 8'h80, 8'h00, 1'b1);
    check_output("t3_acc1");
    check("t3_acc1_const", 32'(out_data), 32'h80);
    apply_stimulus(OP_ACC, 2'd2, 8'h90, 8'h00, 1'b1);
    check_output("t3_acc2");
    check("t3_acc2_const", 32'(out_data), 32'hFF);
    check("t3_acc2_ovf", 32'(out_ovf), 32'(1));
    apply_stimulus(OP_READ, 2'd2, 8'h00, 8'h00, 1'b1);
    check_output("t3_read");
    check("t3_sticky", 32'(ovf_sticky), 32'(3'b100));
    apply_stimulus(OP_CLR, 2'd2, 8'h00, 8'h00, 1'b0);
    check_output("t3_clr2");
    check("t3_sticky_clr", 32'(ovf_sticky), 32'(0));
    apply_stimulus(OP_READ, 2'd2, 8'h00, 8'h00, 1'b0);
    check_output("t3_read2");
    check("t3_read2_const", 32'(out_data), 32'h00);

    // Back-pressure: drain, then stall with a pending result
    @(posedge clk);
    #1;
    check("t4_drained", 32'(out_valid), 32'(0));
    out_ready = 1'b0;
    apply_stimulus(OP_ACC, 2'd0, 8'h05, 8'h00, 1'b0);
    check_output("t4_first");
    drive(OP_ACC, 2'd0, 8'h07, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t4_stall_in_ready", 32'(in_ready),  32'(0));
      check("t4_stall_valid",    32'(out_valid), 32'(1));
      check("t4_stall_data",     32'(out_data),  32'h05);
    end
    out_ready = 1'b1;
    #1;
    check("t4_release_in_ready", 32'(in_ready), 32'(1));
    apply_stimulus(OP_ACC, 2'd0, 8'h07, 8'h00, 1'b0);
    check_output("t4_new");
    check("t4_new_const", 32'(out_data), 32'h0C);
    apply_stimulus(OP_READ, 2'd0, 8'h00, 8'h00, 1'b0);
    check_output("t4_read");

    // Out-of-range channel, then back-to-back accumulation on channel 0
    apply_stimulus(OP_READ, 2'd3, 8'h00, 8'h00, 1'b0);
    check_output("t5_bad");
    check("t5_bad_err", 32'(out_err), 32'(1));
    check("t5_sticky", 32'(ovf_sticky), 32'(model_sticky));
    apply_stimulus(OP_ACC, 2'd3, 8'h11, 8'h00, 1'b0);
    check_output("t5_bad_acc");
    apply_stimulus(OP_CLR, 2'd0, 8'h00, 8'h00, 1'b0);
    check_output("t5_clr");
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(OP_ACC, 2'd0, 8'h01, 8'h00, 1'b0);
      check_output("t5_b2b");
      check("t5_b2b_const", 32'(out_data), 32'(i));
    end
    apply_stimulus(OP_READ, 2'd2, 8'h00, 8'h00, 1'b0);
    check_output("t5_ch2_intact");

    // Reset while a result is pending
    apply_stimulus(OP_ACC, 2'd1, 8'h55, 8'h00, 1'b0);
    check_output("t6_acc");
    out_ready = 1'b0;
    apply_stimulus(OP_READ, 2'd1, 8'h00, 8'h00, 1'b0);
    check_output("t6_pending");
    rst = 1'b1;
    #1;
    check("t6_rst_valid",  32'(out_valid),  32'(0));
    check("t6_rst_data",   32'(out_data),   32'(0));
    check("t6_rst_sticky", 32'(ovf_sticky), 32'(0));
    model_reset();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    apply_stimulus(OP_READ, 2'd1, 8'h00, 8'h00, 1'b0);
    check_output("t6_read");
    check("t6_read_const", 32'(out_data), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
